// File: rtl/shiftregister_ctrl_pkg.sv
// Shared types for the shift-register command sequencer: register mode
// encodings, fill policies and controller states.
package shiftregister_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        SHR  = 2'b01,
        SHL  = 2'b10,
        LOAD = 2'b11
    } sr_mode_t;

    typedef enum logic [1:0] {
        FILL_ZERO  = 2'b00,
        FILL_ONE   = 2'b01,
        FILL_ROT   = 2'b10,
        FILL_ARITH = 2'b11
    } fill_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Direction bit 1 steps toward the MSB.
    function automatic sr_mode_t shift_mode(input logic dir);
        if (dir) begin
            return SHL;
        end else begin
            return SHR;
        end
    endfunction

endpackage

// File: rtl/shiftregister_ctrl.sv
// Command-driven sequencer: loads an external shift register, steps it
// `amount` times with a chosen fill policy, and hands back the result.
module shiftregister_ctrl
    import shiftregister_ctrl_pkg::*;
#(
    parameter int DATASIZE = 8,
    parameter int CNTW     = $clog2(DATASIZE + 1) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [DATASIZE-1:0] cmd_data_i,
    input  logic                cmd_dir_i,
    input  logic [1:0]          cmd_fill_i,
    input  logic [CNTW-1:0]     cmd_amount_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [DATASIZE-1:0] res_data_o,
    output logic                busy_o,
    output logic [1:0]          sr_mode_o,
    output logic [DATASIZE-1:0] sr_load_value_o,
    output logic                sr_ser_in_msb_o,
    output logic                sr_ser_in_lsb_o,
    input  logic [DATASIZE-1:0] sr_value_i
);

    state_t              state_r;
    logic [CNTW-1:0]     count_r;
    logic                dir_r;
    fill_t               fill_r;
    logic [DATASIZE-1:0] data_r;
    logic                cmd_ready_r;
    logic                res_valid_r;
    logic                busy_r;
    sr_mode_t            mode_r;
    logic                ser_msb_s;
    logic                ser_lsb_s;
    logic [DATASIZE-1:0] res_data_s;

    // Sequencer FSM; outputs are set alongside the state they belong to.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r     <= ST_IDLE;
            count_r     <= {CNTW{1'b0}};
            dir_r       <= 1'b0;
            fill_r      <= FILL_ZERO;
            data_r      <= {DATASIZE{1'b0}};
            cmd_ready_r <= 1'b1;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            mode_r      <= HOLD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_r) begin
                        data_r      <= cmd_data_i;
                        dir_r       <= cmd_dir_i;
                        fill_r      <= fill_t'(cmd_fill_i);
                        count_r     <= cmd_amount_i;
                        state_r     <= ST_LOAD;
                        cmd_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        mode_r      <= LOAD;
                    end
                end
                ST_LOAD: begin
                    if (count_r == {CNTW{1'b0}}) begin
                        state_r     <= ST_DONE;
                        mode_r      <= HOLD;
                        res_valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                        mode_r  <= shift_mode(dir_r);
                    end
                end
                ST_SHIFT: begin
                    count_r <= count_r - CNTW'(1);
                    // The register takes its final step on this edge.
                    if (count_r == CNTW'(1)) begin
                        state_r     <= ST_DONE;
                        mode_r      <= HOLD;
                        res_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready_i) begin
                        state_r     <= ST_IDLE;
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        cmd_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    count_r     <= {CNTW{1'b0}};
                    cmd_ready_r <= 1'b1;
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    mode_r      <= HOLD;
                end
            endcase
        end
    end

    // Serial input selection; only the pin feeding the active direction is driven.
    always_comb begin
        ser_msb_s = 1'b0;
        ser_lsb_s = 1'b0;
        if (state_r == ST_SHIFT) begin
            if (dir_r) begin
                case (fill_r)
                    FILL_ZERO:  ser_lsb_s = 1'b0;
                    FILL_ONE:   ser_lsb_s = 1'b1;
                    FILL_ROT:   ser_lsb_s = sr_value_i[DATASIZE-1];
                    FILL_ARITH: ser_lsb_s = 1'b0;
                    default:    ser_lsb_s = 1'b0;
                endcase
            end else begin
                case (fill_r)
                    FILL_ZERO:  ser_msb_s = 1'b0;
                    FILL_ONE:   ser_msb_s = 1'b1;
                    FILL_ROT:   ser_msb_s = sr_value_i[0];
                    FILL_ARITH: ser_msb_s = sr_value_i[DATASIZE-1];
                    default:    ser_msb_s = 1'b0;
                endcase
            end
        end else begin
            ser_msb_s = 1'b0;
            ser_lsb_s = 1'b0;
        end
    end

    // The register sits in HOLD during DONE, so the passthrough is stable.
    always_comb begin
        if (state_r == ST_DONE) begin
            res_data_s = sr_value_i;
        end else begin
            res_data_s = {DATASIZE{1'b0}};
        end
    end

    assign cmd_ready_o     = cmd_ready_r;
    assign res_valid_o     = res_valid_r;
    assign res_data_o      = res_data_s;
    assign busy_o          = busy_r;
    assign sr_mode_o       = mode_r;
    assign sr_load_value_o = data_r;
    assign sr_ser_in_msb_o = ser_msb_s;
    assign sr_ser_in_lsb_o = ser_lsb_s;

endmodule
